// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and field widths for the instruction-memory loader
package imem_loader_pkg;

    localparam int HDR_WIDTH  = 16;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - shifts stream bytes into a big-endian word
// full flags that the byte being loaded now completes the word; the index then wraps to 0.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]      word_next,
    output logic                  full
);

    localparam int NB    = WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign word_next = (word_q << BYTE_WIDTH) | WIDTH'(in_data);
    assign full      = (idx_q == IDX_W'(NB - 1));

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (load) begin
            word_d = word_next;
            idx_d  = full ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a counted byte stream into instruction memory, holding the core while busy
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

    state_t                 state_q, state_d;
    logic [HDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    words_q, words_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic                   pk_clear, pk_load, pk_full, xfer;
    logic [WIDTH-1:0]       pk_word_next;
    logic [HDR_WIDTH-1:0]   n_hdr;

    imem_loader_byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .in_data   (in_data),
        .word_next (pk_word_next),
        .full      (pk_full)
    );

    assign in_ready     = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
    assign busy         = in_ready || (state_q == ST_WR);
    assign mem_we       = (state_q == ST_WR);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERR);
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign xfer         = in_valid && in_ready;
    assign n_hdr        = {count_q[HDR_WIDTH-1 -: BYTE_WIDTH], in_data};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        words_d     = words_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clear    = 1'b0;
        pk_load     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_HDR0;
                    words_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_HDR0: begin
                if (xfer) begin
                    count_d[HDR_WIDTH-1 -: BYTE_WIDTH] = in_data;
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (xfer) begin
                    count_d = n_hdr;
                    if (n_hdr == '0) begin
                        state_d = ST_DONE;
                    end else if (32'(n_hdr) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d  = ST_DATA;
                        addr_d   = '0;
                        pk_clear = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pk_load = 1'b1;
                    // Capture the write port on the completing byte so it is valid throughout WR.
                    if (pk_full) begin
                        state_d     = ST_WR;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = pk_word_next;
                    end
                end
            end
            ST_WR: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = (32'(words_q) + 32'd1 == 32'(count_q)) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory path: accepts a byte stream from a host/debug link, packs it into WIDTH-bit words and issues single-cycle writes into the instruction memory array that the fetch stage later reads.
- Holds the core in reset (busy) while a load session runs.
- Replaces $readmemh preload in hardware builds.

Parameters:
- WIDTH, 32, memory word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; memory depth is 2^ADDR_WIDTH words; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word write address.
- mem_wdata  output  WIDTH  word write data.
- busy  output  1  session in progress; used as core-hold.
- done  output  1  load completed successfully; sticky until next start or rst.
- error  output  1  header rejected; sticky until next start or rst.
- words_loaded  output  ADDR_WIDTH+1  words written in current/last session.

Behaviour:
- Reset: asynchronous, active-high; clk and rst are the only clock/reset.
  - All outputs are 0 during and after reset; state goes to IDLE.
  - Internal count, byte index and word register clear.
- Stream format: 16-bit big-endian word count N, then N*(WIDTH/8) bytes; each word is big-endian (first byte goes to mem_wdata[WIDTH-1:WIDTH-8]).
- State IDLE: in_ready=0, busy=0.
  - start goes to HDR0; words_loaded, done and error clear.
- State HDR0: in_ready=1, busy=1. On a transfer, N[15:8]=in_data, then go to HDR1.
- State HDR1: in_ready=1, busy=1. On a transfer, N[7:0]=in_data, then:
  - N==0: go to DONE.
  - N > 2^ADDR_WIDTH: go to ERR.
  - Otherwise: go to DATA with addr=0 and byte index=0.
- State DATA: in_ready=1, busy=1.
  - Each transfer shifts the byte into the word register LSB side and increments the byte index.
  - The transfer that completes byte WIDTH/8-1 goes to WR.
- State WR: in_ready=0, mem_we=1 for exactly this cycle, with mem_addr=current addr and mem_wdata=the assembled word.
  - Next edge: addr+1, words_loaded+1, byte index=0.
  - Go to DONE if words_loaded+1==N, else DATA.
- State DONE: done=1, busy=0, in_ready=0.
- State ERR: error=1, busy=0, in_ready=0, no writes issued.
- start in DONE or ERR: clear done/error/words_loaded and go to HDR0, same as from IDLE.
- start while busy: ignored, session continues unaffected.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- Throughput: at continuous in_valid, one word per WIDTH/8+1 cycles (5 at WIDTH=32).
- mem_we is never asserted outside WR.
  - mem_addr/mem_wdata are registered and hold their last values otherwise.
- Address wrap: N ≤ 2^ADDR_WIDTH guarantees no address reuse.
  - Internal addr wraps to 0 after the final write at N=2^ADDR_WIDTH; mem_addr shows the last written address.
- Reset mid-session: immediate return to IDLE, no further writes. Memory contents already written remain; integrity is the host's concern.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared defines header:
  - state encodings (IDLE, HDR0, HDR1, DATA, WR, DONE, ERR; 3 bits);
  - HDR_WIDTH=16;
  - BYTE_WIDTH=8.
- One natural sub-module, byte_packer: byte shift register plus byte index, with load/clear inputs and a full flag. It is parameterised by WIDTH.
- The FSM, counters and memory-side registers stay in imem_loader.

Test Plan:
- Reset: assert rst mid-cycle, asynchronously -> all outputs 0 immediately, in_ready=0, mem_we never pulses.
- Two-word load: start, stream 00 02 12 34 56 78 9A BC DE F0 with in_valid constant -> mem_we pulses exactly twice: addr 0 data 12345678, addr 1 data 9ABCDEF0. Then done=1, busy=0, words_loaded=2.
- Empty and oversize headers (ADDR_WIDTH=10):
  - N=0000 -> done=1 right after the header, no writes.
  - N=0401 -> error=1, no writes, in_ready=0.
  - N=0400 streamed fully -> last write at addr 3FF, done=1, words_loaded=400 hex.
- Flow control: in_valid toggled pseudo-randomly, with bytes held during WR -> identical writes as the two-word case. No byte is lost or duplicated, and in_ready=0 on every WR cycle.
- Mid-session: start pulsed during DATA -> ignored, load completes normally. rst after 2 data bytes -> IDLE, outputs 0. A fresh start plus a one-word stream then writes addr 0 correctly.
- Back-to-back sessions: start in DONE -> done, error and words_loaded clear on the next edge, and the second load writes again from addr 0.
